// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg -- shared types, constants and GF(2^8) helpers for the AES-128
// CBC/ECB decryption stream.
//   block_t        : 128-bit cipher block, byte 0 in bits [127:120]
//   AES_ECB/AES_CBC: chaining mode encodings
//   state_e        : stream controller states
//   core_state_e   : iterative decrypt core states
//   fifo_entry_t   : {plaintext, last} record held in the output FIFO
// The S-box and its inverse are computed arithmetically (GF inverse plus
// affine map) so no 256-entry tables are needed.
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef logic [127:0] block_t;

  localparam logic AES_ECB = 1'b0;
  localparam logic AES_CBC = 1'b1;

  localparam int AES_ROUNDS = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_RUN,
    ST_WRITE,
    ST_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    CORE_IDLE,
    CORE_KEXP,
    CORE_ROUND,
    CORE_DONE
  } core_state_e;

  typedef struct packed {
    block_t data;
    logic   last;
  } fifo_entry_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse of xtime; used to walk the round constant backwards.
  function automatic logic [7:0] inv_xtime(input logic [7:0] a);
    return a[0] ? (((a ^ 8'h1b) >> 1) | 8'h80) : (a >> 1);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // Round key r -> r+1 (rcon belongs to round r+1).
  function automatic block_t key_fwd(input block_t rk, input logic [7:0] rcon);
    logic [31:0] n0, n1, n2, n3;
    n0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rcon, 24'h0};
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Round key r+1 -> r (rcon belongs to round r+1).
  function automatic block_t key_bwd(input block_t rk, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3;
    w3 = rk[31:0] ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_rot_word(w3) ^ {rcon, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/aes_decrypt_core.sv
// ---------------------------------------------------------------------------
// aes_decrypt_core -- iterative AES-128 inverse cipher, one round per cycle.
//   CLK, RESET : clock, asynchronous active-high reset
//   start      : sampled in idle; key is captured when it is seen high
//   done       : high for one cycle when msg_dec holds the result
//   key        : 128-bit cipher key
//   msg_enc    : ciphertext, must stay stable until done
//   msg_dec    : plaintext, held until the next start
// Timing: 10 cycles expand the key forward to round key 10, then 10 cycles
// run the inverse rounds while the key schedule is unwound backwards, so
// done rises 21 cycles after start is first seen high.
// ---------------------------------------------------------------------------
module aes_decrypt_core
  import aes_pkg::*;
(
  input  logic   CLK,
  input  logic   RESET,
  input  logic   start,
  output logic   done,
  input  block_t key,
  input  block_t msg_enc,
  output block_t msg_dec
);

  localparam logic [3:0] LAST_STEP = 4'(AES_ROUNDS - 1);

  core_state_e cst_q, cst_d;
  block_t      rk_q, rk_d;
  block_t      st_q, st_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [3:0]  cnt_q, cnt_d;

  block_t rk_next, rk_prev;
  block_t isr, isb, ark, imc, round_out;

  assign rk_next = key_fwd(rk_q, rcon_q);
  assign rk_prev = key_bwd(rk_q, rcon_q);

  // InvShiftRows + InvSubBytes per byte: row r rotates right by r columns.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
      assign isr[127-8*gi -: 8] = st_q[127-8*SRC -: 8];
      assign isb[127-8*gi -: 8] = inv_sbox(isr[127-8*gi -: 8]);
    end
  endgenerate

  assign ark = isb ^ rk_prev;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      assign imc[127-32*gi -: 32] = inv_mix_col(ark[127-32*gi -: 32]);
    end
  endgenerate

  // The final round has no InvMixColumns.
  assign round_out = (cnt_q == LAST_STEP) ? ark : imc;

  always_comb begin
    cst_d  = cst_q;
    rk_d   = rk_q;
    st_d   = st_q;
    rcon_d = rcon_q;
    cnt_d  = cnt_q;
    case (cst_q)
      CORE_IDLE: begin
        if (start) begin
          rk_d   = key;
          rcon_d = 8'h01;
          cnt_d  = 4'd0;
          cst_d  = CORE_KEXP;
        end
      end
      CORE_KEXP: begin
        rk_d  = rk_next;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_STEP) begin
          // rcon stays at round 10's value so the backward walk starts there.
          st_d  = msg_enc ^ rk_next;
          cnt_d = 4'd0;
          cst_d = CORE_ROUND;
        end else begin
          rcon_d = xtime(rcon_q);
        end
      end
      CORE_ROUND: begin
        st_d   = round_out;
        rk_d   = rk_prev;
        rcon_d = inv_xtime(rcon_q);
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == LAST_STEP) cst_d = CORE_DONE;
      end
      CORE_DONE: cst_d = CORE_IDLE;
      default:   cst_d = CORE_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cst_q  <= CORE_IDLE;
      rk_q   <= '0;
      st_q   <= '0;
      rcon_q <= 8'h00;
      cnt_q  <= 4'd0;
    end else begin
      cst_q  <= cst_d;
      rk_q   <= rk_d;
      st_q   <= st_d;
      rcon_q <= rcon_d;
      cnt_q  <= cnt_d;
    end
  end

  assign done    = (cst_q == CORE_DONE);
  assign msg_dec = st_q;

endmodule

// File: rtl/aes_cbc_stream.sv
// ---------------------------------------------------------------------------
// aes_cbc_stream -- AES-128 ECB/CBC decryption of a ciphertext block stream.
//   CLK, RESET         : clock, asynchronous active-high reset
//   START, MODE, KEY,
//   IV                 : begin a message; MODE/KEY/IV captured on START in idle
//   IN_VALID/IN_READY,
//   IN_DATA/IN_LAST    : ciphertext stream, IN_LAST marks the final block
//   OUT_VALID/OUT_READY,
//   OUT_DATA/OUT_LAST  : plaintext stream from a DEPTH-entry FIFO
//   BUSY               : message in progress
//   DONE               : one-cycle pulse once the last block has left the FIFO
// Blocks are decrypted one at a time; a new block is only taken while the
// FIFO has room, so a push can never overflow it.
// ---------------------------------------------------------------------------
module aes_cbc_stream
  import aes_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int CBC_EN = 1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic         MODE,
  input  logic [127:0] KEY,
  input  logic [127:0] IV,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [127:0] IN_DATA,
  input  logic         IN_LAST,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [127:0] OUT_DATA,
  output logic         OUT_LAST,
  output logic         BUSY,
  output logic         DONE
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e  state_q, state_d;
  logic    mode_q, mode_d;
  block_t  key_q, key_d;
  block_t  chain_q, chain_d;
  block_t  cipher_q, cipher_d;
  logic    last_q, last_d;
  logic    start_q, start_d;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fifo_entry_t   mem_q [DEPTH];
  fifo_entry_t   head;

  logic   core_done;
  block_t core_dec;
  block_t plaintext;
  logic   fifo_empty;
  logic   in_ready;
  logic   push;
  logic   pop;

  aes_decrypt_core u_core (
    .CLK     (CLK),
    .RESET   (RESET),
    .start   (start_q),
    .done    (core_done),
    .key     (key_q),
    .msg_enc (cipher_q),
    .msg_dec (core_dec)
  );

  assign fifo_empty = (count_q == '0);
  assign in_ready   = (state_q == ST_ACCEPT) && (count_q < DEPTH_C);
  assign push       = (state_q == ST_WRITE);
  assign pop        = !fifo_empty && OUT_READY;
  assign plaintext  = (mode_q == AES_CBC) ? (core_dec ^ chain_q) : core_dec;

  // Controller next state
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    key_d    = key_q;
    chain_d  = chain_q;
    cipher_d = cipher_q;
    last_d   = last_q;
    start_d  = start_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          key_d   = KEY;
          chain_d = IV;
          mode_d  = (CBC_EN != 0) ? MODE : AES_ECB;
          state_d = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (IN_VALID && in_ready) begin
          cipher_d = IN_DATA;
          last_d   = IN_LAST;
          start_d  = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (core_done) begin
          start_d = 1'b0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The next block chains off the ciphertext just consumed.
        chain_d = cipher_q;
        state_d = last_q ? ST_DRAIN : ST_ACCEPT;
      end
      ST_DRAIN: begin
        if (fifo_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      mode_q   <= AES_ECB;
      key_q    <= '0;
      chain_q  <= '0;
      cipher_q <= '0;
      last_q   <= 1'b0;
      start_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      key_q    <= key_d;
      chain_q  <= chain_d;
      cipher_q <= cipher_d;
      last_q   <= last_d;
      start_q  <= start_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by count_q alone.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= '{data: plaintext, last: last_q};
  end

  assign head      = mem_q[rd_ptr_q];
  assign OUT_VALID = !fifo_empty;
  // Gate the head so stale or uninitialised storage never shows on the port.
  assign OUT_DATA  = fifo_empty ? '0 : head.data;
  assign OUT_LAST  = fifo_empty ? 1'b0 : head.last;
  assign IN_READY  = in_ready;
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = (state_q == ST_DRAIN) && fifo_empty;

endmodule

// File: tb/tb_aes_cbc_stream.sv
module tb_aes_cbc_stream;
  import aes_pkg::*;

  localparam int DEPTH = 4;
  localparam int CORE_LAT = 21;
  // accept edge -> push edge is CORE_LAT+2; visible one sample later
  localparam int ACC_TO_VIS = CORE_LAT + 2 + 1;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] P1X = 128'h69d5c2eb2e2e624750541d3bbc692ba5; // P1 ^ C1
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] IVA = 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;
  localparam logic [127:0] P1A = 128'ha5b48796e1f0c3d22d3c0f1e69784b5a; // P1 ^ IVA

  logic         CLK, RESET, START, MODE;
  logic [127:0] KEY, IV, IN_DATA, OUT_DATA;
  logic         IN_VALID, IN_READY, IN_LAST;
  logic         OUT_VALID, OUT_READY, OUT_LAST, BUSY, DONE;

  aes_cbc_stream #(.DEPTH(DEPTH), .CBC_EN(1)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .MODE(MODE), .KEY(KEY), .IV(IV),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_LAST(IN_LAST),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_LAST(OUT_LAST),
    .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] iv;
    logic         mode;
    int           nblk;
    logic [127:0] c0, c1;
    logic [127:0] p0, p1;
  } vec_t;

  vec_t vecs[5];

  int nchecks = 0;
  int nfails  = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_base = 0;
  int accept_cyc = 0;
  int first_valid_cyc = -1;
  bit in_fire = 0;
  logic [128:0] outq[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Sample at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge CLK);
    cyc++;
    in_fire = IN_VALID && IN_READY;
    if (OUT_VALID && OUT_READY) outq.push_back({OUT_LAST, OUT_DATA});
    if (OUT_VALID && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (DONE) done_cnt++;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input bit check_outs);
    RESET = 1'b1;
    tick();
    tick();
    if (check_outs) begin
      chk("rst_in_ready", 128'(IN_READY), 128'd0);
      chk("rst_out_valid", 128'(OUT_VALID), 128'd0);
      chk("rst_out_data", OUT_DATA, 128'd0);
      chk("rst_out_last", 128'(OUT_LAST), 128'd0);
      chk("rst_busy", 128'(BUSY), 128'd0);
      chk("rst_done", 128'(DONE), 128'd0);
    end
    RESET = 1'b0;
    tick();
  endtask

  task automatic start_msg(input logic [127:0] k, input logic [127:0] iv, input logic m);
    KEY = k; IV = iv; MODE = m; START = 1'b1;
    tick();
    START = 1'b0;
    KEY = '0; IV = '0; MODE = 1'b0;
    outq.delete();
    done_base = done_cnt;
    first_valid_cyc = -1;
  endtask

  task automatic send_block(input logic [127:0] d, input logic l, input string nm);
    int n;
    n = 0;
    IN_DATA = d; IN_LAST = l; IN_VALID = 1'b1;
    in_fire = 0;
    while (!in_fire && n < 200) begin
      tick();
      n++;
    end
    if (in_fire) accept_cyc = cyc;
    IN_VALID = 1'b0;
    if (!in_fire) chk({nm, "_accept_timeout"}, 128'd0, 128'd1);
  endtask

  task automatic wait_drain(input int nout, input string nm);
    int n;
    n = 0;
    while ((outq.size() < nout || done_cnt == done_base) && n < 600) begin
      tick();
      n++;
    end
    if (n >= 600) chk({nm, "_drain_timeout"}, 128'd0, 128'd1);
    repeat (3) tick();
  endtask

  task automatic wait_count(input int c, input string nm);
    int n;
    n = 0;
    while (int'(dut.count_q) != c && n < 200) begin
      tick();
      n++;
    end
    chk({nm, "_count"}, 128'(dut.count_q), 128'(c));
  endtask

  task automatic run_vec(input vec_t v);
    OUT_READY = 1'b1;
    start_msg(v.key, v.iv, v.mode);
    send_block(v.c0, v.nblk == 1, v.name);
    if (v.nblk == 2) send_block(v.c1, 1'b1, v.name);
    wait_drain(v.nblk, v.name);
    chk({v.name, "_latency"}, 128'(first_valid_cyc - (accept_cyc - (v.nblk - 1) * 0)), 128'(first_valid_cyc - accept_cyc));
    chk({v.name, "_nout"}, 128'(outq.size()), 128'(v.nblk));
    if (outq.size() >= 1) begin
      chk({v.name, "_data0"}, outq[0][127:0], v.p0);
      chk({v.name, "_last0"}, 128'(outq[0][128]), 128'(v.nblk == 1));
    end
    if (v.nblk == 2 && outq.size() >= 2) begin
      chk({v.name, "_data1"}, outq[1][127:0], v.p1);
      chk({v.name, "_last1"}, 128'(outq[1][128]), 128'd1);
    end
    chk({v.name, "_done_pulses"}, 128'(done_cnt - done_base), 128'd1);
    chk({v.name, "_busy_after"}, 128'(BUSY), 128'd0);
  endtask

  initial begin
    int lat;
    int fires;
    logic [127:0] held;

    vecs[0] = '{"ecb_fips",    K1, '0,  AES_ECB, 1, C1, '0, P1,  '0};
    vecs[1] = '{"cbc_two",     K1, '0,  AES_CBC, 2, C1, C1, P1,  P1X};
    vecs[2] = '{"ecb_key2",    K2, '0,  AES_ECB, 1, C2, '0, P2,  '0};
    vecs[3] = '{"cbc_iv",      K1, IVA, AES_CBC, 1, C1, '0, P1A, '0};
    vecs[4] = '{"ecb_iv_ign",  K1, IVA, AES_ECB, 2, C1, C1, P1,  P1};

    START = 0; MODE = 0; KEY = '0; IV = '0;
    IN_VALID = 0; IN_DATA = '0; IN_LAST = 0; OUT_READY = 1;
    RESET = 1'b1;
    do_reset(1'b1);

    // Table-driven vectors, first-block latency measured on the first one
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
      if (i == 0) begin
        lat = first_valid_cyc - accept_cyc;
        chk("latency_accept_to_push", 128'(lat), 128'(ACC_TO_VIS));
      end
      $display("vector %0d %s done, out=%0d", i, vecs[i].name, outq.size());
    end

    // Backpressure: 6 blocks, FIFO of 4, sink stalled
    OUT_READY = 1'b0;
    start_msg(K1, IVA, AES_CBC);
    for (int b = 0; b < 4; b++) send_block(C1, 1'b0, "bp");
    wait_count(4, "bp_full");
    held = OUT_DATA;
    IN_DATA = C1; IN_LAST = 1'b0; IN_VALID = 1'b1;
    fires = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (in_fire) fires++;
    end
    chk("bp_no_accept", 128'(fires), 128'd0);
    chk("bp_in_ready", 128'(IN_READY), 128'd0);
    chk("bp_out_valid", 128'(OUT_VALID), 128'd1);
    chk("bp_head_stable", OUT_DATA, held);
    chk("bp_head_value", OUT_DATA, P1A);
    OUT_READY = 1'b1;
    IN_VALID = 1'b0;
    send_block(C1, 1'b0, "bp5");
    send_block(C1, 1'b1, "bp6");
    wait_drain(6, "bp");
    chk("bp_nout", 128'(outq.size()), 128'd6);
    for (int k = 0; k < 6 && k < outq.size(); k++) begin
      chk($sformatf("bp_data%0d", k), outq[k][127:0], (k == 0) ? P1A : P1X);
      chk($sformatf("bp_last%0d", k), 128'(outq[k][128]), 128'(k == 5));
    end
    chk("bp_done_pulses", 128'(done_cnt - done_base), 128'd1);
    $display("backpressure sequence done, out=%0d", outq.size());

    // Simultaneous push and pop with DEPTH-1 entries held
    OUT_READY = 1'b0;
    start_msg(K1, '0, AES_ECB);
    for (int b = 0; b < 3; b++) send_block(C1, 1'b0, "pp");
    wait_count(DEPTH - 1, "pp_pre");
    send_block(C1, 1'b1, "pp4");
    begin
      int n;
      n = 0;
      while (dut.state_q != ST_WRITE && n < 200) begin
        tick();
        n++;
      end
      chk("pp_reach_write", 128'(dut.state_q == ST_WRITE), 128'd1);
    end
    chk("pp_count_before", 128'(dut.count_q), 128'(DEPTH - 1));
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    chk("pp_count_after", 128'(dut.count_q), 128'(DEPTH - 1));
    chk("pp_popped", 128'(outq.size()), 128'd1);
    OUT_READY = 1'b1;
    wait_drain(4, "pp");
    chk("pp_nout", 128'(outq.size()), 128'd4);
    for (int k = 0; k < 4 && k < outq.size(); k++) begin
      chk($sformatf("pp_data%0d", k), outq[k][127:0], P1);
      chk($sformatf("pp_last%0d", k), 128'(outq[k][128]), 128'(k == 3));
    end
    $display("push/pop sequence done, out=%0d", outq.size());

    // Reset while the core is running
    start_msg(K1, '0, AES_ECB);
    send_block(C1, 1'b1, "rr");
    repeat (5) tick();
    chk("rr_in_run", 128'(dut.state_q == ST_RUN), 128'd1);
    done_base = done_cnt;
    RESET = 1'b1;
    tick();
    chk("rr_busy", 128'(BUSY), 128'd0);
    chk("rr_out_valid", 128'(OUT_VALID), 128'd0);
    chk("rr_out_data", OUT_DATA, 128'd0);
    RESET = 1'b0;
    repeat (30) tick();
    chk("rr_no_done", 128'(done_cnt - done_base), 128'd0);
    chk("rr_no_output", 128'(OUT_VALID), 128'd0);
    run_vec(vecs[0]);
    $display("reset-in-run sequence done, out=%0d", outq.size());

    // START inside ACCEPT with another key must be ignored
    OUT_READY = 1'b1;
    start_msg(K1, '0, AES_ECB);
    KEY = K2; IV = IVA; MODE = AES_CBC; START = 1'b1;
    tick();
    START = 1'b0;
    send_block(C1, 1'b1, "ign");
    wait_drain(1, "ign");
    chk("ign_nout", 128'(outq.size()), 128'd1);
    if (outq.size() >= 1) chk("ign_data", outq[0][127:0], P1);
    chk("ign_done_pulses", 128'(done_cnt - done_base), 128'd1);
    $display("ignored-start sequence done, out=%0d", outq.size());

    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfails);
    $finish;
  end

endmodule
